// File: rtl/hatch_fetch.sv
// hatch_fetch: answers hatch instruction-fetch requests by reading the
// 6-byte big-endian instruction at hatch_address from a 32-bit word memory,
// one read outstanding at a time, two or three words per instruction.
module hatch_fetch #(
    parameter logic [47:0] FILL_INSN = 48'h0,
    parameter int unsigned MEM_AW    = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       hatch_address,
    output logic [47:0]       hatch_instruction,
    output logic              hatch_valid,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_rvalid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state;
    logic [31:0]       cur_addr;
    logic              cur_ok;
    logic [1:0]        word_idx;
    logic [63:0]       word_buf;

    logic              addr_new;
    logic              begin_fetch;
    logic [MEM_AW-1:0] start_word;
    logic [1:0]        offset;
    logic              last_word;
    logic [95:0]       line;
    logic [95:0]       aligned;
    logic [47:0]       insn;

    // Fetch-start decision and byte extraction from the captured words
    always_comb begin
        addr_new    = !cur_ok || (hatch_address != cur_addr);
        // A completing read for a stale address restarts immediately; its data is dropped.
        begin_fetch = (((state == S_IDLE) || (state == S_DONE)) && addr_new) ||
                      ((state == S_WAIT) && mem_rvalid && addr_new);
        start_word  = hatch_address[MEM_AW+1:2];
        offset      = cur_addr[1:0];
        last_word   = (word_idx == ((offset == 2'd3) ? 2'd2 : 2'd1));
        // Earliest word sits in the top bits; two-word fetches are left-justified.
        line        = (offset == 2'd3) ? {word_buf, mem_rdata}
                                       : {word_buf[31:0], mem_rdata, 32'h0};
        aligned     = line << {offset, 3'b000};
        insn        = aligned[95:48];
    end

    // Fetch FSM with registered memory-port and hatch outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= S_IDLE;
            cur_addr          <= '0;
            cur_ok            <= 1'b0;
            word_idx          <= '0;
            word_buf          <= '0;
            mem_rd            <= 1'b0;
            mem_addr          <= '0;
            hatch_valid       <= 1'b0;
            hatch_instruction <= FILL_INSN;
        end else if (begin_fetch) begin
            state             <= S_ISSUE;
            cur_addr          <= hatch_address;
            cur_ok            <= 1'b1;
            word_idx          <= '0;
            mem_rd            <= 1'b1;
            mem_addr          <= start_word;
            hatch_valid       <= 1'b0;
            hatch_instruction <= FILL_INSN;
        end else begin
            case (state)
                S_ISSUE: begin
                    mem_rd <= 1'b0;
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        if (last_word) begin
                            state             <= S_DONE;
                            hatch_valid       <= 1'b1;
                            hatch_instruction <= insn;
                        end else begin
                            word_buf <= {word_buf[31:0], mem_rdata};
                            word_idx <= word_idx + 2'd1;
                            mem_rd   <= 1'b1;
                            mem_addr <= mem_addr + 1'b1;
                            state    <= S_ISSUE;
                        end
                    end
                end
                S_IDLE, S_DONE: begin
                    state <= state;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hatch_fetch.sv
// Testbench for hatch_fetch: word-memory responder with one-cycle read
// latency, scoreboard queues for expected read addresses and instructions.
module tb_hatch_fetch;

    localparam logic [47:0] FILL = 48'hF1F1_F1F1_F1F1;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] hatch_address;
    logic [47:0] hatch_instruction;
    logic        hatch_valid;
    logic [29:0] mem_addr;
    logic        mem_rd;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;

    hatch_fetch #(.FILL_INSN(FILL), .MEM_AW(30)) dut (
        .clk               (clk),
        .rst               (rst),
        .hatch_address     (hatch_address),
        .hatch_instruction (hatch_instruction),
        .hatch_valid       (hatch_valid),
        .mem_addr          (mem_addr),
        .mem_rd            (mem_rd),
        .mem_rdata         (mem_rdata),
        .mem_rvalid        (mem_rvalid)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_img [logic [29:0]];
    logic [29:0] exp_addr_q [$];
    logic [47:0] exp_insn_q [$];
    int unsigned start_cyc = 0;
    int unsigned exp_lat   = 0;
    int unsigned stray_issued = 0;
    int unsigned stray_served = 0;

    typedef struct {
        logic [31:0]       addr;
        logic [2:0][31:0]  w;
        int unsigned       n;
        logic [47:0]       insn;
    } vec_t;

    vec_t vt [6];

    task automatic check(input string name, input logic [47:0] got, input logic [47:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] rd_word(input logic [29:0] a);
        if (mem_img.exists(a)) return mem_img[a];
        return 32'h0;
    endfunction

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] w2, input int unsigned n, input logic [47:0] insn);
        vec_t v;
        v.addr = a;
        v.w[0] = w0;
        v.w[1] = w1;
        v.w[2] = w2;
        v.n    = n;
        v.insn = insn;
        return v;
    endfunction

    // Memory responder: rvalid exactly one cycle after each mem_rd pulse; also injects stray pulses
    logic [29:0] resp_a;
    initial begin
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (stray_issued != stray_served) begin
                stray_served++;
                @(posedge clk); #1;
                mem_rdata  = 32'hBAD0_BAD0;
                mem_rvalid = 1'b1;
                @(posedge clk); #1;
                mem_rvalid = 1'b0;
            end else if (mem_rd === 1'b1) begin
                resp_a = mem_addr;
                @(posedge clk); #1;
                mem_rdata  = rd_word(resp_a);
                mem_rvalid = 1'b1;
                @(posedge clk); #1;
                mem_rvalid = 1'b0;
            end
        end
    end

    // Scoreboard monitor: every read pulse and every rising hatch_valid is checked
    logic [29:0] mon_a;
    logic        prev_valid = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (mem_rd === 1'b1) begin
                checks++;
                if (exp_addr_q.size() == 0) begin
                    errors++;
                    $display("FAIL mem_rd_unexpected: read at mem_addr %h, none expected", mem_addr);
                end else begin
                    mon_a = exp_addr_q.pop_front();
                    if (mem_addr !== mon_a) begin
                        errors++;
                        $display("FAIL mem_addr: got %h expected %h", mem_addr, mon_a);
                    end
                end
            end
            if (hatch_valid === 1'b1 && prev_valid !== 1'b1) begin
                checks++;
                if (exp_insn_q.size() == 0) begin
                    errors++;
                    $display("FAIL valid_unexpected: insn %h, no instruction expected", hatch_instruction);
                end else begin
                    checks--;
                    check("instruction", hatch_instruction, exp_insn_q.pop_front());
                end
                if (exp_lat != 0) check("latency", 48'(cyc - start_cyc), 48'(exp_lat));
            end
            prev_valid = hatch_valid;
        end
    end

    task automatic load(input vec_t v);
        for (int unsigned i = 0; i < v.n; i++) mem_img[30'(v.addr[31:2] + i)] = v.w[i];
    endtask

    task automatic expect_fetch(input vec_t v);
        for (int unsigned i = 0; i < v.n; i++) exp_addr_q.push_back(30'(v.addr[31:2] + i));
        exp_insn_q.push_back(v.insn);
        exp_lat = 2 * v.n + 1;
    endtask

    task automatic wait_valid(input string name);
        int unsigned k = 0;
        while (hatch_valid !== 1'b1 && k < 60) begin
            @(negedge clk); #1;
            k++;
        end
        checks++;
        if (hatch_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: hatch_valid %b after %0d cycles, required 1", name, hatch_valid, k);
        end
        check({name, "_reads_done"}, 48'(exp_addr_q.size()), 48'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_valid"}, 48'(hatch_valid), 48'd0);
        check({name, "_insn"}, hatch_instruction, FILL);
        check({name, "_mem_rd"}, 48'(mem_rd), 48'd0);
        check({name, "_mem_addr"}, 48'(mem_addr), 48'd0);
    endtask

    vec_t rv;

    initial begin
        // Byte layout: word W holds bytes 4W..4W+3 from [31:24] down to [7:0]
        vt[0] = mk(32'h0000_0000, 32'h0B00_0000, 32'h0007_0000, 32'h0, 2, 48'h0B00_0000_0007);
        vt[1] = mk(32'h0000_0007, 32'h0000_0001, 32'h0000_1001, 32'h0000_0000, 3, 48'h0100_0010_0100);
        vt[2] = mk(32'h0000_0022, 32'h1122_3344, 32'h5566_7788, 32'h0, 2, 48'h3344_5566_7788);
        vt[3] = mk(32'h0000_0041, 32'hA1B2_C3D4, 32'hE5F6_0718, 32'h0, 2, 48'hB2C3_D4E5_F607);
        vt[4] = mk(32'hFFFF_FFFD, 32'hCAFE_BABE, 32'h1234_5678, 32'h0, 2, 48'hFEBA_BE12_3456);
        vt[5] = mk(32'hFFFF_FFFF, 32'h0102_0304, 32'h0506_0708, 32'h090A_0B0C, 3, 48'h0405_0607_0809);
        rv    = mk(32'h0000_0100, 32'h0102_0304, 32'h0506_0708, 32'h0, 2, 48'h0102_0304_0506);

        rst = 1'b1;
        hatch_address = rv.addr;
        load(rv);
        repeat (2) @(negedge clk);
        stray_issued++;
        repeat (4) @(negedge clk);
        #1;
        check_reset_outputs("reset");

        // First edge after release fetches the address already on the bus
        @(posedge clk); #1;
        rst = 1'b0;
        start_cyc = cyc;
        expect_fetch(rv);
        wait_valid("post_reset");

        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            load(vt[i]);
            expect_fetch(vt[i]);
            hatch_address = vt[i].addr;
            start_cyc = cyc;
            @(negedge clk); #1;
            @(negedge clk); #1;
            check($sformatf("vec%0d_drop_valid", i), 48'(hatch_valid), 48'd0);
            check($sformatf("vec%0d_drop_insn", i), hatch_instruction, FILL);
            wait_valid($sformatf("vec%0d", i));
            check($sformatf("vec%0d_mem_addr_hold", i), 48'(mem_addr),
                  48'(30'(vt[i].addr[31:2] + vt[i].n - 1)));
        end

        // Stray rvalid while holding a valid instruction
        stray_issued++;
        repeat (4) @(negedge clk);
        #1;
        check("stray_done_valid", 48'(hatch_valid), 48'd1);
        check("stray_done_insn", hatch_instruction, vt[5].insn);
        check("stray_done_mem_addr", 48'(mem_addr), 48'h1);

        // Address switch 0x0D -> 0x13 while the word-3 read is outstanding
        @(posedge clk); #1;
        mem_img[30'd3] = 32'hAAAA_AAAA;
        mem_img[30'd4] = 32'h0000_00C1;
        mem_img[30'd5] = 32'hC2C3_C4C5;
        mem_img[30'd6] = 32'hC6FF_FFFF;
        exp_addr_q.push_back(30'd3);
        exp_addr_q.push_back(30'd4);
        exp_addr_q.push_back(30'd5);
        exp_addr_q.push_back(30'd6);
        exp_insn_q.push_back(48'hC1C2_C3C4_C5C6);
        exp_lat = 0;
        hatch_address = 32'h0000_000D;
        @(posedge clk);
        @(posedge clk); #1;
        hatch_address = 32'h0000_0013;
        wait_valid("switch");
        check("switch_mem_addr_hold", 48'(mem_addr), 48'd6);

        // Reset during WAIT, then a fresh fetch of the same address after release
        @(posedge clk); #1;
        exp_addr_q.push_back(30'h10);
        hatch_address = vt[3].addr;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        exp_addr_q.delete();
        exp_insn_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        start_cyc = cyc;
        expect_fetch(vt[3]);
        wait_valid("after_reset");

        repeat (4) @(negedge clk);
        check("final_insn_queue", 48'(exp_insn_q.size()), 48'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
